paramult_sched: RTL and testbench
=================================

PARAMULT_SCHED -- requirements
Module: paramult_sched

Interface
REQ-001 Parameter: MULT_LAT, default 4, cycles from mul_v high to the matching mul_res_v high at the multiplier (legal 1..8).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_v / req1_v  input  1  requester n presents an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  256 each  16 lanes x 16 bit operands.
REQ-007 req0_rdy / req1_rdy  output  1  grant; a transfer occurs when reqn_v and reqn_rdy are both high.
REQ-008 halt  input  1  blocks new grants; in-flight operations still complete.
REQ-009 mul_v  output  1  issue strobe to the 16x16 multiplier array.
REQ-010 mul_a, mul_b  output  256 each  registered operands to the multiplier.
REQ-011 mul_res_v  input  1  multiplier result valid.
REQ-012 mul_res  input  256  multiplier result (16 lanes x 16 bit).
REQ-013 res0_v / res1_v  output  1  one-cycle result strobe to the owning requester.
REQ-014 res0_data / res1_data  output  256 each  registered result, held until the next result for that requester.
REQ-015 busy  output  1  high while any operation is in flight or a mul_v is pending.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 reqn_rdy SHALL be combinational: low when halt is high; otherwise high only for the arbitration winner among requesters with reqn_v high.
REQ-018 At most one transfer SHALL occur per cycle; the two rdy outputs are never high together.
REQ-019 On a transfer in cycle T: mul_v=1 and mul_a/mul_b = the winner's operands in cycle T+1; otherwise mul_v=0 and mul_a/mul_b hold their last values.
REQ-020 Tag pipeline: MULT_LAT-deep shift register of {valid, owner}; mul_v shifts in {1, winner} and no issue shifts in {0, x}.
REQ-021 mul_res_v SHALL be checked against the pipeline tail: mul_res_v=1 with the tail valid routes mul_res to resN_data and pulses resN_v on the next cycle (N = tail owner).
REQ-022 End-to-end latency: a transfer in cycle T produces resN_v in cycle T+MULT_LAT+2 (T+6 by default).
REQ-023 mul_res_v=1 with the tail invalid, or the tail valid with mul_res_v=0, SHALL set err=1; in the latter case the tagged result is dropped and no resN_v is pulsed. err clears only on rst.
REQ-024 Back-to-back issue at one per cycle SHALL be sustained; results return in issue order.
REQ-025 busy = mul_v OR any valid bit in the tag pipeline.
REQ-026 halt asserted in the cycle of a would-be transfer SHALL suppress that transfer; requester state is unaffected.
REQ-027 The last-grant pointer SHALL update only on a transfer.

Reset
REQ-028 During rst: reqn_rdy=0, mul_v=0, resN_v=0, busy=0, and err=0.
REQ-029 During rst, mul_a, mul_b and resN_data SHALL be cleared to 0, the tag pipeline to all-invalid, and the last-grant pointer to requester 1.
REQ-030 rst asserted mid-operation SHALL discard all in-flight tags; no resN_v is pulsed for operations issued before rst.
REQ-031 The first cycle after rst deasserts is a normal arbitration cycle.

Configuration
REQ-032 Macro PARAMULT_SCHED_RR_EN defined: round-robin arbitration; when both requesters are valid, the winner is the requester not granted last.
REQ-033 PARAMULT_SCHED_RR_EN undefined: fixed priority, with req0 always winning over req1; the pointer logic is not compiled.

Verification
REQ-034 Single op: req0_v=1 with lanes a=0x0100, b=0x0200 at T, MULT_LAT=4 -> mul_v at T+1; res0_v at T+6; res0_data lanes = multiplier output; res1_v stays 0.
REQ-035 Contention: req0_v=req1_v=1 for 4 cycles after reset -> with RR_EN, grants go 0,1,0,1; without RR_EN, grants go 0,0,0,0.
REQ-036 Back-to-back: 8 consecutive req1 transfers -> 8 consecutive res1_v pulses in order, and busy falls 1 cycle after the last mul_res_v.
REQ-037 Halt: halt=1 with both requesters valid for 3 cycles -> rdy=0 and no mul_v; in-flight results still delivered.
REQ-038 Error: inject mul_res_v=1 with an empty pipeline -> err=1 next cycle and held until rst; no resN_v.
REQ-039 Reset mid-flight: rst at T+3 after an issue -> no res0_v afterwards and all outputs at reset values.

Source files
------------

// File: rtl/paramult_sched.sv
// rtl/paramult_sched.sv - two-requester issue scheduler and result router for a pipelined 16-lane multiplier
// Define PARAMULT_SCHED_RR_EN for round-robin arbitration; the default build is fixed priority with req0 first.
module paramult_sched #(
  parameter int MULT_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_v,
  input  logic [255:0] req0_a,
  input  logic [255:0] req0_b,
  output logic         req0_rdy,
  input  logic         req1_v,
  input  logic [255:0] req1_a,
  input  logic [255:0] req1_b,
  output logic         req1_rdy,
  input  logic         halt,
  output logic         mul_v,
  output logic [255:0] mul_a,
  output logic [255:0] mul_b,
  input  logic         mul_res_v,
  input  logic [255:0] mul_res,
  output logic         res0_v,
  output logic [255:0] res0_data,
  output logic         res1_v,
  output logic [255:0] res1_data,
  output logic         busy,
  output logic         err
);

  logic                pick0;
  logic                grant0;
  logic                grant1;
  logic                mul_owner;
  logic [MULT_LAT-1:0] tag_v;
  logic [MULT_LAT-1:0] tag_o;
  logic                tail_v;
  logic                tail_o;

`ifdef PARAMULT_SCHED_RR_EN
  logic last_grant;
`endif

  always_comb begin
    pick0 = req0_v;
`ifdef PARAMULT_SCHED_RR_EN
    // On contention the requester that did not win last time goes first.
    if (req0_v && req1_v) pick0 = last_grant;
`endif
    grant0 = !rst && !halt && req0_v && pick0;
    grant1 = !rst && !halt && req1_v && !pick0;
  end

  assign req0_rdy = grant0;
  assign req1_rdy = grant1;

  assign tail_v = tag_v[MULT_LAT-1];
  assign tail_o = tag_o[MULT_LAT-1];
  assign busy   = mul_v || (|tag_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_v     <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_owner <= 1'b0;
      tag_v     <= '0;
      tag_o     <= '0;
      res0_v    <= 1'b0;
      res1_v    <= 1'b0;
      res0_data <= '0;
      res1_data <= '0;
      err       <= 1'b0;
    end else begin
      mul_v <= grant0 || grant1;
      if (grant0 || grant1) begin
        mul_a     <= grant1 ? req1_a : req0_a;
        mul_b     <= grant1 ? req1_b : req0_b;
        mul_owner <= grant1;
      end

      // Tags track the multiplier pipeline so the tail lines up with mul_res_v.
      tag_v[0] <= mul_v;
      tag_o[0] <= mul_owner;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end

      res0_v <= mul_res_v && tail_v && !tail_o;
      res1_v <= mul_res_v && tail_v && tail_o;
      if (mul_res_v && tail_v && !tail_o) res0_data <= mul_res;
      if (mul_res_v && tail_v && tail_o)  res1_data <= mul_res;

      // A result without a tag, or a tag without a result, is a protocol error.
      if (mul_res_v != tail_v) err <= 1'b1;
    end
  end

`ifdef PARAMULT_SCHED_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      last_grant <= grant1;
    end
  end
`endif

endmodule

// File: tb/tb_paramult_sched.sv
// tb/tb_paramult_sched.sv - directed self-checking bench for paramult_sched with a behavioural multiplier
module tb_paramult_sched;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_v, req1_v, req0_rdy, req1_rdy, halt;
  logic [255:0] req0_a, req0_b, req1_a, req1_b;
  logic         mul_v, mul_res_v;
  logic [255:0] mul_a, mul_b, mul_res;
  logic         res0_v, res1_v, busy, err;
  logic [255:0] res0_data, res1_data;
  logic         inj, drop;

  int vecs = 0;
  int errs = 0;

  logic [LAT-1:0] mq_v;
  logic [255:0]   mq_d [LAT];

  paramult_sched #(.MULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_v(req0_v), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(req0_rdy),
    .req1_v(req1_v), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(req1_rdy),
    .halt(halt), .mul_v(mul_v), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res_v(mul_res_v), .mul_res(mul_res),
    .res0_v(res0_v), .res0_data(res0_data), .res1_v(res1_v), .res1_data(res1_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Q8 fixed-point lane product keeps small operands from truncating to zero.
  function automatic logic [255:0] qmul(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [31:0]  p;
    for (int j = 0; j < 16; j++) begin
      p = a[j*16 +: 16] * b[j*16 +: 16];
      r[j*16 +: 16] = p[23:8];
    end
    return r;
  endfunction

  function automatic logic [255:0] mk(input logic [15:0] base);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[j*16 +: 16] = base + 16'(j);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq_v <= '0;
    end else begin
      mq_v[0] <= mul_v;
      mq_d[0] <= qmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) begin
        mq_v[i] <= mq_v[i-1];
        mq_d[i] <= mq_d[i-1];
      end
    end
  end

  assign mul_res_v = (mq_v[LAT-1] && !drop) || inj;
  assign mul_res   = mq_d[LAT-1];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req0_v = 1'b0; req1_v = 1'b0; halt = 1'b0; inj = 1'b0; drop = 1'b0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; halt = 1'b0; inj = 1'b0; drop = 1'b0;
    req0_v = 1'b1; req1_v = 1'b1; req0_a = mk(16'h0011); req0_b = mk(16'h0022);
    req1_a = mk(16'h0033); req1_b = mk(16'h0044);
    step; step;
    vecs++; if (req0_rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy0 got %b want 0", req0_rdy); end
    vecs++; if (req1_rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy1 got %b want 0", req1_rdy); end
    vecs++; if (mul_v !== 1'b0) begin errs++; $display("FAIL reset_mul_v got %b want 0", mul_v); end
    vecs++; if ({res0_v, res1_v} !== 2'b00) begin errs++; $display("FAIL reset_res_v got %b want 00", {res0_v, res1_v}); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
    vecs++; if ({mul_a, mul_b} !== 512'h0) begin errs++; $display("FAIL reset_mul_ab got %h want 0", mul_a); end
    vecs++; if ({res0_data, res1_data} !== 512'h0) begin errs++; $display("FAIL reset_res_data got %h want 0", res0_data); end
    req0_v = 1'b0; req1_v = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [255:0] a, b;
    do_reset;
    a = {16{16'h0100}}; b = {16{16'h0200}};
    req0_a = a; req0_b = b; req0_v = 1'b1;
    #1;
    vecs++; if ({req0_rdy, req1_rdy} !== 2'b10) begin errs++; $display("FAIL single_rdy got %b want 10", {req0_rdy, req1_rdy}); end
    step;
    req0_v = 1'b0;
    vecs++; if (mul_v !== 1'b1) begin errs++; $display("FAIL single_mul_v got %b want 1", mul_v); end
    vecs++; if (mul_a !== a || mul_b !== b) begin errs++; $display("FAIL single_mul_ab got %h want %h", mul_a, a); end
    for (int k = 2; k <= 7; k++) begin
      step;
      vecs++; if (res0_v !== (k == 6)) begin errs++; $display("FAIL single_res0_v_t%0d got %b want %b", k, res0_v, (k == 6)); end
      vecs++; if (res1_v !== 1'b0) begin errs++; $display("FAIL single_res1_v_t%0d got %b want 0", k, res1_v); end
    end
    vecs++; if (res0_data !== {16{16'h0200}}) begin errs++; $display("FAIL single_res0_data got %h want %h", res0_data, {16{16'h0200}}); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_contention;
    logic [3:0] exp0;
`ifdef PARAMULT_SCHED_RR_EN
    exp0 = 4'b0101;
`else
    exp0 = 4'b1111;
`endif
    do_reset;
    req0_a = mk(16'h0100); req0_b = mk(16'h0100);
    req1_a = mk(16'h0200); req1_b = mk(16'h0100);
    req0_v = 1'b1; req1_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if ({req0_rdy, req1_rdy} !== {exp0[i], !exp0[i]}) begin errs++; $display("FAIL contention_grant%0d got %b want %b", i, {req0_rdy, req1_rdy}, {exp0[i], !exp0[i]}); end
      step;
    end
    req0_v = 1'b0; req1_v = 1'b0;
    repeat (10) step;
  endtask

  task automatic test_back_to_back;
    logic [255:0] exp_d [8];
    logic [31:0]  bz;
    int n, prev, last_mr;
    do_reset;
    n = 0; prev = -1; last_mr = -1; bz = '0;
    for (int c = 0; c < 24; c++) begin
      req1_v = (c < 8);
      if (c < 8) begin
        req1_a = mk(16'h0100 + 16'(c) * 16'h0080);
        req1_b = mk(16'h0300 - 16'(c) * 16'h0010);
        exp_d[c] = qmul(req1_a, req1_b);
        #1;
        vecs++; if (req1_rdy !== 1'b1) begin errs++; $display("FAIL b2b_rdy%0d got %b want 1", c, req1_rdy); end
      end
      step;
      bz[c] = busy;
      if (mul_res_v) last_mr = c;
      if (res0_v) begin vecs++; errs++; $display("FAIL b2b_res0_v at %0d got 1 want 0", c); end
      if (res1_v) begin
        if (n < 8) begin
          vecs++; if (res1_data !== exp_d[n]) begin errs++; $display("FAIL b2b_data%0d got %h want %h", n, res1_data, exp_d[n]); end
        end
        if (n > 0) begin
          vecs++; if (c !== prev + 1) begin errs++; $display("FAIL b2b_gap%0d got %0d want %0d", n, c, prev + 1); end
        end
        prev = c; n++;
      end
    end
    req1_v = 1'b0;
    vecs++; if (n !== 8) begin errs++; $display("FAIL b2b_count got %0d want 8", n); end
    vecs++; if (last_mr < 0 || last_mr > 30 || bz[last_mr] !== 1'b1 || bz[last_mr+1] !== 1'b0) begin errs++; $display("FAIL b2b_busy_fall got last_mr=%0d busy=%b want busy 1 then 0", last_mr, bz); end
  endtask

  task automatic test_halt;
    int n0, n1;
    do_reset;
    req0_a = mk(16'h0200); req0_b = mk(16'h0180); req0_v = 1'b1;
    step;
    halt = 1'b1; req1_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if ({req0_rdy, req1_rdy} !== 2'b00) begin errs++; $display("FAIL halt_rdy%0d got %b want 00", i, {req0_rdy, req1_rdy}); end
      step;
      vecs++; if (mul_v !== 1'b0) begin errs++; $display("FAIL halt_mul_v%0d got %b want 0", i, mul_v); end
    end
    halt = 1'b0; req0_v = 1'b0; req1_v = 1'b0;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      step;
      if (res0_v) n0++;
      if (res1_v) n1++;
    end
    vecs++; if (n0 !== 1 || n1 !== 0) begin errs++; $display("FAIL halt_inflight got res0=%0d res1=%0d want 1 0", n0, n1); end
    vecs++; if (res0_data !== qmul(mk(16'h0200), mk(16'h0180))) begin errs++; $display("FAIL halt_data got %h want %h", res0_data, qmul(mk(16'h0200), mk(16'h0180))); end
  endtask

  task automatic test_error;
    int n;
    do_reset;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_pre got %b want 0", err); end
    inj = 1'b1;
    step;
    inj = 1'b0;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_set got %b want 1", err); end
    step;
    vecs++; if ({res0_v, res1_v} !== 2'b00) begin errs++; $display("FAIL err_res_v got %b want 00", {res0_v, res1_v}); end
    repeat (3) step;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b want 1", err); end
    do_reset;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_clear got %b want 0", err); end
    req0_a = mk(16'h0100); req0_b = mk(16'h0100); req0_v = 1'b1;
    step;
    req0_v = 1'b0; drop = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step;
      if (res0_v || res1_v) n++;
    end
    drop = 1'b0;
    vecs++; if (n !== 0) begin errs++; $display("FAIL err_drop_res got %0d want 0", n); end
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_drop_flag got %b want 1", err); end
  endtask

  task automatic test_reset_midflight;
    int n;
    do_reset;
    req0_a = mk(16'h0400); req0_b = mk(16'h0300); req0_v = 1'b1;
    step;
    req0_v = 1'b0;
    step; step;
    rst = 1'b1;
    step;
    vecs++; if ({mul_v, busy, err, res0_v, res1_v, req0_rdy} !== 6'b0) begin errs++; $display("FAIL midrst_ctl got %b want 000000", {mul_v, busy, err, res0_v, res1_v, req0_rdy}); end
    vecs++; if (mul_a !== 256'h0 || res0_data !== 256'h0) begin errs++; $display("FAIL midrst_data got %h want 0", mul_a); end
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step;
      if (res0_v) n++;
    end
    vecs++; if (n !== 0) begin errs++; $display("FAIL midrst_res0 got %0d want 0", n); end
    vecs++; if (err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL midrst_after got err=%b busy=%b want 0 0", err, busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_back_to_back;
    test_halt;
    test_error;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
